// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter / timer with terminal-count pulse.
// One-shot mode stops in DONE at zero; periodic mode wraps from zero back to the
// captured reload value, giving a period of reload+1 enabled cycles.
module down_counter_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] load_val_in,
   input  logic             en_in,
   input  logic             auto_reload_in,
   output logic [WIDTH-1:0] Q_out,
   output logic             tc_out,
   output logic             busy_out,
   output logic             done_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count, count_nxt;
   logic [WIDTH-1:0] reload, reload_nxt;
   logic             tc, tc_nxt;

   // State, count, reload and terminal-count registers; reset overrides load.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         tc     <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         reload <= reload_nxt;
         tc     <= tc_nxt;
      end
   end

   // Next-state / next-count: load beats enable; tc only on the 1 -> 0 step.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload;
      tc_nxt     = 1'b0;
      if (load_in) begin
         count_nxt  = load_val_in;
         reload_nxt = load_val_in;
         state_nxt  = (load_val_in != '0) ? RUN : DONE;
      end else begin
         case (state)
            RUN: begin
               if (en_in) begin
                  if (count == '0) begin
                     // Zero is only held in RUN in periodic mode: wrap to reload.
                     count_nxt = reload;
                  end else if (count == WIDTH'(1)) begin
                     count_nxt = '0;
                     tc_nxt    = 1'b1;
                     if (!auto_reload_in) state_nxt = DONE;
                  end else begin
                     count_nxt = count - WIDTH'(1);
                  end
               end
            end
            DONE: begin
               count_nxt = '0;
            end
            default: begin
               count_nxt = count;
            end
         endcase
      end
   end

   // Outputs come straight from registered state.
   assign Q_out    = count;
   assign tc_out   = tc;
   assign busy_out = (state == RUN);
   assign done_out = (state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus process advances a
// behavioural model and queues expected outputs; a monitor pops and compares.
module tb_down_counter_timer;

   localparam int W = 3;

   logic         clk_in = 1'b0;
   logic         reset_in = 1'b0;
   logic         load_in = 1'b0;
   logic [W-1:0] load_val_in = '0;
   logic         en_in = 1'b0;
   logic         auto_reload_in = 1'b0;
   logic [W-1:0] Q_out;
   logic         tc_out, busy_out, done_out;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .load_in        (load_in),
      .load_val_in    (load_val_in),
      .en_in          (en_in),
      .auto_reload_in (auto_reload_in),
      .Q_out          (Q_out),
      .tc_out         (tc_out),
      .busy_out       (busy_out),
      .done_out       (done_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [W-1:0] q;
      logic         tc;
      logic         busy;
      logic         done;
      int           tag;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: mode 0 = idle, 1 = counting, 2 = finished.
   int m_q = 0;
   int m_reload = 0;
   int m_mode = 0;
   int m_tc = 0;

   task automatic model(input logic rst, input logic ld, input int v,
                        input logic en, input logic ar);
      if (rst) begin
         m_q = 0; m_reload = 0; m_mode = 0; m_tc = 0;
      end else if (ld) begin
         m_q = v; m_reload = v; m_tc = 0;
         m_mode = (v != 0) ? 1 : 2;
      end else begin
         m_tc = 0;
         if (m_mode == 1 && en) begin
            if (m_q == 0) begin
               m_q = m_reload;
            end else begin
               m_q = m_q - 1;
               if (m_q == 0) begin
                  m_tc = 1;
                  if (!ar) m_mode = 2;
               end
            end
         end
      end
   endtask

   task automatic step(input logic rst, input logic ld, input int v,
                       input logic en, input logic ar);
      exp_t e;
      reset_in       = rst;
      load_in        = ld;
      load_val_in    = W'(v);
      en_in          = en;
      auto_reload_in = ar;
      model(rst, ld, v, en, ar);
      e.q    = W'(m_q);
      e.tc   = (m_tc != 0);
      e.busy = (m_mode == 1);
      e.done = (m_mode == 2);
      e.tag  = cyc;
      cyc++;
      sb.push_back(e);
      @(posedge clk_in);
      #1;
   endtask

   // Monitor: each clock the DUT presents a new output set, compare it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (Q_out !== e.q || tc_out !== e.tc || busy_out !== e.busy || done_out !== e.done) begin
               errors++;
               $display("FAIL cycle%0d: got Q=%0d tc=%b busy=%b done=%b, expected Q=%0d tc=%b busy=%b done=%b",
                        e.tag, Q_out, tc_out, busy_out, done_out, e.q, e.tc, e.busy, e.done);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // 1: reset, then enable with no load
      repeat (2) step(1, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 1, 0);
      // 2: one-shot from 5
      step(0, 1, 5, 0, 0);
      repeat (16) step(0, 0, 0, 1, 0);
      // 3: periodic from 7
      step(0, 1, 7, 0, 1);
      repeat (20) step(0, 0, 0, 1, 1);
      // 4: enable gaps at Q=2 and at Q=0
      step(0, 1, 3, 0, 1);
      step(0, 0, 0, 1, 1);
      repeat (3) step(0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 1, 1);
      repeat (3) step(0, 0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 1, 1);
      // 5: restart at Q=2, then zero load
      step(0, 1, 4, 0, 0);
      repeat (2) step(0, 0, 0, 1, 0);
      step(0, 1, 6, 1, 0);
      repeat (2) step(0, 0, 0, 1, 0);
      step(0, 1, 0, 1, 1);
      repeat (4) step(0, 0, 0, 1, 1);
      // 6: reset and load on the same edge while running at Q=3
      step(0, 1, 5, 0, 0);
      repeat (2) step(0, 0, 0, 1, 0);
      step(1, 1, 5, 1, 0);
      repeat (4) step(0, 0, 0, 1, 1);
      // Randomized phase
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 60) == 0, ($urandom % 10) == 0, int'($urandom % (1 << W)),
              ($urandom % 4) != 0, ($urandom % 3) != 0);
      end
      step(0, 0, 0, 0, 0);
      @(posedge clk_in);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
